// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: opcodes, state
// encodings and datapath select encodings.
package mc_ctrl_pkg;

  localparam int OP_R_TYPE = 0;
  localparam int OP_J      = 2;
  localparam int OP_BEQ    = 4;
  localparam int OP_ADDI   = 8;
  localparam int OP_LW     = 35;
  localparam int OP_SW     = 43;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_ILLEGAL   = 4'd12,
    S_TIMEOUT   = 4'd13
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mc_control_wait_timer.sv
// Memory-handshake watchdog: counts consecutive stalled cycles and flags the
// cycle in which the LIMIT-th stall would occur. LIMIT=0 disables it.
module mc_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic waiting,
  input  logic clear,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_count <= '0;
    end else if (waiting) begin
      r_count <= r_count + 1'b1;
    end
  end

  generate
    if (LIMIT > 0) begin : g_enabled
      assign expired = waiting && (r_count == W'(LIMIT - 1));
    end else begin : g_disabled
      assign expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS main control FSM with memory watchdog, illegal-op trap and
// retired-instruction counter. Define MC_CTRL_ADDI_EN to add the addi path.
module mc_control
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  op,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_count
);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_count;
  logic             w_waiting;
  logic             w_expired;
  logic             w_retire;
  logic             w_timer_clear;

  assign w_waiting = !mem_ready &&
                     (r_state inside {S_FETCH, S_MEM_READ, S_MEM_WRITE});
  assign w_timer_clear = rst || !w_waiting || (w_next_state != r_state);

  mc_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .waiting (w_waiting),
    .clear   (w_timer_clear),
    .expired (w_expired)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:
        if (mem_ready)      w_next_state = S_DECODE;
        else if (w_expired) w_next_state = S_TIMEOUT;
      S_DECODE: begin
        if (op == OP_W'(OP_R_TYPE))                          w_next_state = S_EXECUTE;
        else if (op == OP_W'(OP_LW) || op == OP_W'(OP_SW))   w_next_state = S_MEM_ADDR;
        else if (op == OP_W'(OP_BEQ))                        w_next_state = S_BRANCH;
        else if (op == OP_W'(OP_J))                          w_next_state = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
        else if (op == OP_W'(OP_ADDI))                       w_next_state = S_ADDI_EXEC;
`endif
        else                                                 w_next_state = S_ILLEGAL;
      end
      S_MEM_ADDR:
        w_next_state = (op == OP_W'(OP_SW)) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:
        if (mem_ready)      w_next_state = S_MEM_WB;
        else if (w_expired) w_next_state = S_TIMEOUT;
      S_MEM_WRITE:
        if (mem_ready)      w_next_state = S_FETCH;
        else if (w_expired) w_next_state = S_TIMEOUT;
      S_EXECUTE:   w_next_state = S_R_WB;
`ifdef MC_CTRL_ADDI_EN
      S_ADDI_EXEC: w_next_state = S_ADDI_WB;
`endif
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB:
        w_next_state = S_FETCH;
      S_ILLEGAL, S_TIMEOUT:
        w_next_state = r_state;
      default:
        w_next_state = S_FETCH;
    endcase
  end

  // MEM_WRITE only retires when it actually returns to FETCH, not on timeout.
  assign w_retire = (w_next_state == S_FETCH) &&
                    (r_state inside {S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_retire) r_count <= r_count + 1'b1;
    end
  end

  assign state       = r_state;
  assign instr_count = r_count;

  // Moore decode; forced quiet during reset so an aborted instruction writes nothing.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PC_ALU;
    illegal_op    = 1'b0;
    mem_timeout   = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:    alu_src_b = SRCB_IMM_SH;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PC_ALUOUT;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PC_JUMP;
        end
`ifdef MC_CTRL_ADDI_EN
        S_ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_ADDI_WB:   reg_write = 1'b1;
`endif
        S_ILLEGAL:   illegal_op  = 1'b1;
        S_TIMEOUT:   mem_timeout = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: per-instruction expected state sequences
// derived from the instruction latency/timeout rules, checked every cycle.
module tb_mc_control;

  localparam int MT = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    op = 6'd0;
  logic          mem_ready = 1'b0;
  logic          pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write;
  logic          i_or_d, mem_to_reg, reg_dst, alu_src_a;
  logic [1:0]    alu_src_b, alu_op, pc_source;
  logic [3:0]    state;
  logic          illegal_op, mem_timeout;
  logic [CW-1:0] instr_count;
  logic [17:0]   outs;

  int total = 0;
  int bad = 0;
  int model_cnt = 0;
  int nsteps = 0;

  mc_control #(.OP_W(6), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign outs = {pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
                 i_or_d, mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_op,
                 pc_source, illegal_op, mem_timeout};

  // Output table per state, written from the state descriptions.
  function automatic logic [17:0] exp_outs(input int st, input logic rdy);
    logic pw, pwc, irw, rw, mr, mw, iod, m2r, rd, asa, il, to;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, irw, rw, mr, mw, iod, m2r, rd, asa, il, to} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      0:  begin mr = 1'b1; asb = 2'b01; irw = rdy; pw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  begin mr = 1'b1; iod = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  begin mw = 1'b1; iod = 1'b1; end
      6:  begin asa = 1'b1; aop = 2'b10; end
      7:  begin rw = 1'b1; rd = 1'b1; end
      8:  begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; end
      9:  begin pw = 1'b1; psrc = 2'b10; end
      10: begin asa = 1'b1; asb = 2'b10; end
      11: rw = 1'b1;
      12: il = 1'b1;
      13: to = 1'b1;
      default: ;
    endcase
    return {pw, pwc, irw, rw, mr, mw, iod, m2r, rd, asa, asb, aop, psrc, il, to};
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic step(input logic rdy, input int es);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = rdy;
    #1;
    nsteps++;
    total++;
    if (state !== 4'(es)) begin
      bad++;
      $display("FAIL state: got %0d want %0d (op=%0d)", state, es, op);
    end
    total++;
    if (outs !== exp_outs(es, rdy)) begin
      bad++;
      $display("FAIL outputs st=%0d: got %b want %b", es, outs, exp_outs(es, rdy));
    end
    total++;
    if (instr_count !== CW'(model_cnt)) begin
      bad++;
      $display("FAIL instr_count: got %0d want %0d", instr_count, CW'(model_cnt));
    end
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst = 1'b1;
      mem_ready = rnd_bit();
      #1;
      total++;
      if (outs !== 18'd0) begin
        bad++;
        $display("FAIL reset_outputs: got %b want all zero", outs);
      end
    end
    model_cnt = 0;
  endtask

  task automatic retire();
    model_cnt = (model_cnt + 1) % (1 << CW);
  endtask

  task automatic trap_steps(input int st, input int n);
    for (int i = 0; i < n; i++) step(rnd_bit(), st);
  endtask

  task automatic mem_wait(input int st, input int w, output bit trapped);
    trapped = 1'b0;
    for (int k = 0; k <= w; k++) begin
      step(k == w, st);
      if (k != w && k == MT - 1) begin
        trap_steps(13, 3);
        trapped = 1'b1;
        return;
      end
    end
  endtask

  // One instruction: fw stall cycles in FETCH, mw stall cycles in the memory state.
  task automatic run_instr(input logic [5:0] o, input int fw, input int mw, output bit trapped);
    trapped = 1'b0;
    op = o;
    mem_wait(0, fw, trapped);
    if (trapped) return;
    step(rnd_bit(), 1);
    case (o)
      6'd0:  begin step(rnd_bit(), 6); step(rnd_bit(), 7); retire(); end
      6'd35: begin
        step(rnd_bit(), 2);
        mem_wait(3, mw, trapped);
        if (trapped) return;
        step(rnd_bit(), 4);
        retire();
      end
      6'd43: begin
        step(rnd_bit(), 2);
        mem_wait(5, mw, trapped);
        if (trapped) return;
        retire();
      end
      6'd4:  begin step(rnd_bit(), 8); retire(); end
      6'd2:  begin step(rnd_bit(), 9); retire(); end
`ifdef MC_CTRL_ADDI_EN
      6'd8:  begin step(rnd_bit(), 10); step(rnd_bit(), 11); retire(); end
`endif
      default: begin trap_steps(12, 4); trapped = 1'b1; end
    endcase
  endtask

  task automatic test_reset();
    do_reset(2);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    total++;
    if (state !== 4'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
    total++;
    if (instr_count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", instr_count); end
  endtask

  task automatic test_rtype();
    bit tr;
    do_reset(2);
    run_instr(6'd0, 0, 0, tr);
    step(1'b1, 0);
    total++;
    if (instr_count !== CW'(1)) begin bad++; $display("FAIL rtype_count: got %0d want 1", instr_count); end
  endtask

  task automatic test_lw_wait();
    bit tr;
    int c0;
    do_reset(2);
    c0 = nsteps;
    run_instr(6'd35, 0, 3, tr);
    total++;
    if (nsteps - c0 != 8) begin bad++; $display("FAIL lw_latency: got %0d want 8", nsteps - c0); end
  endtask

  task automatic test_back_to_back();
    bit tr;
    do_reset(2);
    run_instr(6'd43, 0, 0, tr);
    run_instr(6'd4, 0, 0, tr);
    run_instr(6'd2, 0, 0, tr);
    @(negedge clk);
    #1;
    total++;
    if (instr_count !== CW'(3)) begin bad++; $display("FAIL b2b_count: got %0d want 3", instr_count); end
  endtask

  task automatic test_illegal();
    bit tr;
    do_reset(2);
    run_instr(6'd13, 0, 0, tr);
    trap_steps(12, 16);
    total++;
    if (illegal_op !== 1'b1) begin bad++; $display("FAIL illegal_flag: got %b want 1", illegal_op); end
    do_reset(1);
    step(1'b1, 0);
    total++;
    if (illegal_op !== 1'b0) begin bad++; $display("FAIL illegal_clear: got %b want 0", illegal_op); end
  endtask

  task automatic test_timeout();
    bit tr;
    do_reset(2);
    run_instr(6'd0, MT, 0, tr);
    total++;
    if (mem_timeout !== 1'b1) begin bad++; $display("FAIL timeout_flag: got %b want 1", mem_timeout); end
    do_reset(2);
    run_instr(6'd0, MT - 1, 0, tr);
    total++;
    if (mem_timeout !== 1'b0) begin bad++; $display("FAIL timeout_edge: got %b want 0", mem_timeout); end
  endtask

  task automatic test_rst_in_write();
    do_reset(2);
    op = 6'd43;
    step(1'b1, 0);
    step(rnd_bit(), 1);
    step(rnd_bit(), 2);
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    total++;
    if (state !== 4'd5 || outs !== 18'd0) begin
      bad++;
      $display("FAIL rst_in_write: got state=%0d outs=%b want state=5 outs=0", state, outs);
    end
    model_cnt = 0;
    step(1'b1, 0);
  endtask

  task automatic test_addi();
    bit tr;
    do_reset(2);
    run_instr(6'd8, 0, 0, tr);
  endtask

  task automatic test_random();
    bit tr;
    logic [5:0] legal [6] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8};
    logic [5:0] o;
    int fw, mw;
    do_reset(2);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) o = 6'($urandom_range(0, 63));
      else o = legal[$urandom_range(0, 5)];
      fw = ($urandom_range(0, 9) == 0) ? MT : $urandom_range(0, 2);
      mw = ($urandom_range(0, 9) == 0) ? MT : $urandom_range(0, 3);
      run_instr(o, fw, mw, tr);
      if (tr) do_reset(2);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_rst_in_write();
    test_addi();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
